// File: rtl/window_generator_3x3_if.sv
// Raster pixel stream in, 3x3 window plus strobes out.
// master: pixel source / window sink. slave: window_generator_3x3. sof exists only with WINDOW_SOF_EN.
interface window_generator_3x3_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic [PIXEL_WIDTH-1:0] pixel_in;
  logic                   pixel_valid;
`ifdef WINDOW_SOF_EN
  logic                   sof;
`endif
  logic [PIXEL_WIDTH-1:0] pixel0, pixel1, pixel2;
  logic [PIXEL_WIDTH-1:0] pixel3, pixel4, pixel5;
  logic [PIXEL_WIDTH-1:0] pixel6, pixel7, pixel8;
  logic                   window_valid;
  logic                   frame_done;

`ifdef WINDOW_SOF_EN
  modport master (
    output pixel_in, pixel_valid, sof,
    input  pixel0, pixel1, pixel2, pixel3, pixel4,
    input  pixel5, pixel6, pixel7, pixel8,
    input  window_valid, frame_done
  );
  modport slave (
    input  pixel_in, pixel_valid, sof,
    output pixel0, pixel1, pixel2, pixel3, pixel4,
    output pixel5, pixel6, pixel7, pixel8,
    output window_valid, frame_done
  );
`else
  modport master (
    output pixel_in, pixel_valid,
    input  pixel0, pixel1, pixel2, pixel3, pixel4,
    input  pixel5, pixel6, pixel7, pixel8,
    input  window_valid, frame_done
  );
  modport slave (
    input  pixel_in, pixel_valid,
    output pixel0, pixel1, pixel2, pixel3, pixel4,
    output pixel5, pixel6, pixel7, pixel8,
    output window_valid, frame_done
  );
`endif
endinterface

// File: rtl/window_generator_3x3.sv
// Raster-to-3x3-window generator: two line buffers plus a 3x3 shift array.
// Ports: clk, rst_n (async, active-low), bus (slave). Optional WINDOW_SOF_EN adds sof resync.
module window_generator_3x3 #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  window_generator_3x3_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] R_TWO  = RW'(2);

  logic [PIXEL_WIDTH-1:0] r_lb0 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] r_lb1 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] r_win [9];
  logic [CW-1:0]          r_col;
  logic [RW-1:0]          r_row;
  logic                   r_wv;
  logic                   r_fd;

  logic                   w_sof;
  logic [CW-1:0]          w_col;
  logic [RW-1:0]          w_row;
  logic [PIXEL_WIDTH-1:0] w_lb0;
  logic [PIXEL_WIDTH-1:0] w_lb1;

`ifdef WINDOW_SOF_EN
  assign w_sof = bus.sof & bus.pixel_valid;
`else
  assign w_sof = 1'b0;
`endif

  // sof overrides the counters so the pixel lands at (0,0)
  assign w_col = w_sof ? '0 : r_col;
  assign w_row = w_sof ? '0 : r_row;
  assign w_lb0 = r_lb0[w_col];
  assign w_lb1 = r_lb1[w_col];

  // line buffers are unreset; stale data is masked by r >= 2
  always_ff @(posedge clk) begin
    if (bus.pixel_valid) begin
      r_lb0[w_col] <= w_lb1;
      r_lb1[w_col] <= bus.pixel_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
      r_col <= '0;
      r_row <= '0;
      r_wv  <= 1'b0;
      r_fd  <= 1'b0;
    end else if (bus.pixel_valid) begin
      for (int k = 0; k < 3; k++) begin
        r_win[3*k]   <= r_win[3*k+1];
        r_win[3*k+1] <= r_win[3*k+2];
      end
      r_win[2] <= w_lb0;
      r_win[5] <= w_lb1;
      r_win[8] <= bus.pixel_in;
      r_wv <= (w_row >= R_TWO) && (w_col >= C_TWO);
      r_fd <= (w_row == R_LAST) && (w_col == C_LAST);
      if (w_col == C_LAST) begin
        r_col <= '0;
        r_row <= (w_row == R_LAST) ? '0 : w_row + RW'(1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end else begin
      r_wv <= 1'b0;
      r_fd <= 1'b0;
    end
  end

  assign bus.pixel0       = r_win[0];
  assign bus.pixel1       = r_win[1];
  assign bus.pixel2       = r_win[2];
  assign bus.pixel3       = r_win[3];
  assign bus.pixel4       = r_win[4];
  assign bus.pixel5       = r_win[5];
  assign bus.pixel6       = r_win[6];
  assign bus.pixel7       = r_win[7];
  assign bus.pixel8       = r_win[8];
  assign bus.window_valid = r_wv;
  assign bus.frame_done   = r_fd;
endmodule

// File: tb/tb_window_generator_3x3.sv
// Randomised and directed bench for window_generator_3x3 on a 4x4 image.
// Reference model keeps the current frame as a 2D image and cuts windows from it.
module tb_window_generator_3x3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_generator_3x3_if #(.PIXEL_WIDTH(PW)) bus ();

  window_generator_3x3 #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  logic [PW-1:0] dw [9];
  assign dw[0] = bus.pixel0;
  assign dw[1] = bus.pixel1;
  assign dw[2] = bus.pixel2;
  assign dw[3] = bus.pixel3;
  assign dw[4] = bus.pixel4;
  assign dw[5] = bus.pixel5;
  assign dw[6] = bus.pixel6;
  assign dw[7] = bus.pixel7;
  assign dw[8] = bus.pixel8;

  int n_err = 0;
  int n_chk = 0;

  int img [H][W];
  int pos;
  int exp_win [9];
  bit known;
  bit exp_wv;
  bit exp_fd;

  int first_ref [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
  int last_ref  [9] = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
  int med_ref   [4] = '{6, 7, 10, 11};

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int median9(int a [9]);
    int s [9];
    int t;
    s = a;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s[4];
  endfunction

  task automatic model(bit v, int p, bit s);
    int r, c;
    bit s_eff;
`ifdef WINDOW_SOF_EN
    s_eff = s;
`else
    s_eff = 1'b0 & s;
`endif
    if (!v) begin
      exp_wv = 1'b0;
      exp_fd = 1'b0;
      return;
    end
    if (s_eff) pos = 0;
    r = pos / W;
    c = pos % W;
    img[r][c] = p;
    exp_wv = (r >= 2) && (c >= 2);
    exp_fd = (pos == W * H - 1);
    known = exp_wv;
    if (exp_wv)
      for (int i = 0; i < 9; i++)
        exp_win[i] = img[r - 2 + i / 3][c - 2 + i % 3];
    pos = (pos + 1) % (W * H);
  endtask

  task automatic compare();
    chk("window_valid", int'(bus.window_valid), int'(exp_wv));
    chk("frame_done", int'(bus.frame_done), int'(exp_fd));
    if (known)
      for (int i = 0; i < 9; i++)
        chk($sformatf("pixel%0d", i), int'(dw[i]), exp_win[i]);
  endtask

  task automatic step(bit v, int p, bit s);
    bus.pixel_valid = v;
    bus.pixel_in    = p[PW-1:0];
`ifdef WINDOW_SOF_EN
    bus.sof = s;
`endif
    @(posedge clk);
    #1;
    model(v, p, s);
    compare();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.pixel_valid = 1'b0;
    #2;
    chk("rst_wv", int'(bus.window_valid), 0);
    chk("rst_fd", int'(bus.frame_done), 0);
    for (int i = 0; i < 9; i++)
      chk($sformatf("rst_pixel%0d", i), int'(dw[i]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pos = 0;
    known = 1'b1;
    exp_wv = 1'b0;
    exp_fd = 1'b0;
    for (int i = 0; i < 9; i++) exp_win[i] = 0;
  endtask

  // Stream base..base+15 and check pulse count, first/last windows, medians
  task automatic frame_check(string tag, int base, bit gaps, bit sof1);
    int nwin;
    int first_w [9];
    int last_w [9];
    int meds [$];
    nwin = 0;
    for (int k = 0; k < W * H; k++) begin
      step(1'b1, base + k, sof1 && (k == 0));
      if (bus.window_valid) begin
        for (int i = 0; i < 9; i++) begin
          if (nwin == 0) first_w[i] = int'(dw[i]);
          last_w[i] = int'(dw[i]);
        end
        meds.push_back(median9(last_w));
        nwin++;
      end
      if (gaps) step(1'b0, $urandom_range(0, 255), 1'b0);
    end
    step(1'b0, 0, 1'b0);
    chk({tag, "_nwin"}, nwin, (W - 2) * (H - 2));
    if (nwin == (W - 2) * (H - 2)) begin
      for (int i = 0; i < 9; i++) begin
        chk({tag, "_first"}, first_w[i], first_ref[i] + base - 1);
        chk({tag, "_last"}, last_w[i], last_ref[i] + base - 1);
      end
      for (int i = 0; i < 4; i++)
        chk({tag, "_median"}, meds[i], med_ref[i] + base - 1);
    end
  endtask

  initial begin
    bus.pixel_in = '0;
    bus.pixel_valid = 1'b0;
`ifdef WINDOW_SOF_EN
    bus.sof = 1'b0;
`endif
    pos = 0;
    known = 1'b0;
    do_reset();

    frame_check("cont", 1, 1'b0, 1'b0);
    frame_check("gaps", 1, 1'b1, 1'b0);
    frame_check("b2b_a", 1, 1'b0, 1'b0);
    frame_check("b2b_b", 101, 1'b0, 1'b0);

    for (int k = 1; k <= 7; k++) step(1'b1, k, 1'b0);
    do_reset();
    frame_check("post_rst", 1, 1'b0, 1'b0);

`ifdef WINDOW_SOF_EN
    for (int k = 1; k <= 5; k++) step(1'b1, k, k == 1);
    frame_check("sof", 1, 1'b0, 1'b1);
`endif

    for (int n = 0; n < 3 * W * H * 2; n++)
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 255), 1'b0);

    repeat (2) step(1'b0, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
